axis_operand_unpacker: RTL
==========================

// Module: axis_operand_unpacker
// PURPOSE
//  Sits directly behind the NDP_core AXI-Stream slave port, upstream of the systolic array grid.
//  Accepts 32-bit words, each packing two FP16 values. For every k-step it assembles an
//  activation column (A_LEN values) and a weight row (B_LEN values), then issues them as one
//  valid/ready beat. One packet = K_DEPTH steps, terminated by tlast on the final word.
// PARAMETERS
//  WIDTH    16  element width in bits; two elements per 32-bit word
//  A_LEN    4   activation elements per step (SYS_HEIGHT*ARR_HEIGHT); must be even
//  B_LEN    64  weight elements per step (SYS_WIDTH*ARR_WIDTH); must be even
//  K_DEPTH  21  k-steps per packet (MATRIX_A_WIDTH)
// PORTS
//  clk            in   1              single clock
//  reset          in   1              asynchronous, active-high
//  s_axis_tdata   in   32             packed element pair
//  s_axis_tvalid  in   1              input word valid
//  s_axis_tlast   in   1              final word of packet
//  s_axis_tready  out  1              word accepted when tvalid & tready
//  out_a          out  A_LEN*WIDTH    activation column; element e at [e*WIDTH +: WIDTH]
//  out_b          out  B_LEN*WIDTH    weight row; element e at [e*WIDTH +: WIDTH]
//  out_valid      out  1              step beat valid
//  out_ready      in   1              consumer accepts beat
//  out_first      out  1              beat is k-step 0
//  out_last       out  1              beat is k-step K_DEPTH-1
//  err_len        out  1              sticky packet-framing error
// BEHAVIOUR
//  Reset: all outputs 0 (s_axis_tready=0 while reset is high). k=0, word index=0, state COLLECT_A.
//  Word unpack: word w of a segment: [15:0] -> element 2w, [31:16] -> element 2w+1.
//  Segment order per step: A_LEN/2 A-words, then B_LEN/2 B-words (default 2 + 32 = 34 words).
//  FSM:
//   COLLECT_A: tready=1. Each accepted word fills the A staging buffer.
//     After word A_LEN/2-1 is accepted -> COLLECT_B.
//   COLLECT_B: tready=1. Each accepted word fills the B staging buffer.
//     On word B_LEN/2-1 (the step-final word):
//       if slot free (out_valid=0 or out_ready=1 this cycle): load output regs (final word
//         written straight into out_b top pair) -> COLLECT_A;
//       else -> HOLD.
//   HOLD: tready=0. When out_valid=0 or out_ready=1: load output regs -> COLLECT_A.
//  Latency: out_valid rises on the cycle after the step-final word is accepted (or after the HOLD
//   release edge). out_first/out_last are captured with the beat from k: k==0 / k==K_DEPTH-1.
//  Output handshake: beat held stable until out_valid&out_ready. out_valid drops the next cycle
//   unless a new beat loads on the same edge (back-to-back allowed, no bubble).
//  k counter: increments on each output load; wraps K_DEPTH-1 -> 0.
//  Framing:
//   - tlast accepted on any word other than the step-final word of k=K_DEPTH-1: set err_len,
//     discard partial step, k=0, word index=0 -> COLLECT_A. Beats already issued are unaffected.
//   - Step-final word of k=K_DEPTH-1 accepted without tlast: set err_len; beat still issued and
//     k wraps to 0 (resync on step boundary).
//   - err_len is cleared only by reset.
//  tvalid low mid-segment: pure stall, no state change. No data is dropped while tready=1.
//  Reset mid-packet: immediate clear of all state; the next accepted word is A-word 0 of k=0.
// TESTING
//  1 Full packet, out_ready=1, element value = index (A: 0..3, B: 0x100+e) -> 21 beats;
//    out_a=={3,2,1,0}, first only on beat 0, last only on beat 20, err_len=0.
//  2 Word 0x3C00_4000 as A-word 0 -> out_a[15:0]=16'h4000, out_a[31:16]=16'h3C00.
//  3 out_ready=0 for 100 cycles after beat 0 -> next step's 34 words are accepted, then
//    tready=0 (HOLD); beat 0 held stable; release -> beat 1 valid on the next cycle, no loss.
//  4 tlast on B-word 10 of k=5 -> err_len=1, no beat for k=5; next word is A-word 0 of k=0,
//    and the following good packet yields 21 correct beats.
//  5 Step-final word of k=20 without tlast -> err_len=1, out_last=1 on that beat, k wraps to 0.
//  6 Reset asserted on word 17 of k=3 -> outputs 0 asynchronously; a fresh packet passes
//    exactly as in test 1.
//  7 Random tvalid gaps with random out_ready, 100 packets -> beats match the reference model.

Source files
------------

// File: rtl/axis_operand_unpacker.sv
// Unpacks AXI-Stream words (two elements each) into one activation column plus one
// weight row per k-step, issued as a single valid/ready beat with packet framing checks.
module axis_operand_unpacker #(
  parameter int WIDTH   = 16,
  parameter int A_LEN   = 4,
  parameter int B_LEN   = 64,
  parameter int K_DEPTH = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [A_LEN*WIDTH-1:0]   out_a,
  output logic [B_LEN*WIDTH-1:0]   out_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     err_len
);
  localparam int A_WORDS = A_LEN / 2;
  localparam int B_WORDS = B_LEN / 2;
  localparam int IW      = $clog2(A_WORDS + B_WORDS);
  localparam int KW      = $clog2(K_DEPTH + 1);

  typedef enum logic [1:0] {COLLECT_A, COLLECT_B, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            widx_q, widx_d;
  logic [KW-1:0]            k_q, k_d;
  logic [A_LEN*WIDTH-1:0]   a_stage_q, a_stage_d;
  logic [B_LEN*WIDTH-1:0]   b_stage_q, b_stage_d;
  logic [A_LEN*WIDTH-1:0]   out_a_q, out_a_d;
  logic [B_LEN*WIDTH-1:0]   out_b_q, out_b_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_first_q, out_first_d;
  logic                     out_last_q, out_last_d;
  logic                     err_q, err_d;

  logic accept, slot_free, load, step_final, final_of_packet;

  assign s_axis_tready = ~reset & (state_q != HOLD);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign slot_free     = ~out_valid_q | out_ready;
  assign step_final    = (state_q == COLLECT_B) && (widx_q == IW'(B_WORDS - 1));
  assign final_of_packet = step_final && (k_q == KW'(K_DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    k_d         = k_q;
    a_stage_d   = a_stage_q;
    b_stage_d   = b_stage_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    load        = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      COLLECT_A: begin
        if (accept) begin
          for (int i = 0; i < A_WORDS; i++)
            if (widx_q == IW'(i)) a_stage_d[i*2*WIDTH +: 2*WIDTH] = s_axis_tdata[2*WIDTH-1:0];
          if (widx_q == IW'(A_WORDS - 1)) begin
            widx_d  = '0;
            state_d = COLLECT_B;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      COLLECT_B: begin
        if (accept) begin
          for (int i = 0; i < B_WORDS; i++)
            if (widx_q == IW'(i)) b_stage_d[i*2*WIDTH +: 2*WIDTH] = s_axis_tdata[2*WIDTH-1:0];
          if (step_final) begin
            widx_d = '0;
            if (final_of_packet && !s_axis_tlast) err_d = 1'b1;
            if (slot_free) begin
              load    = 1'b1;
              state_d = COLLECT_A;
            end else begin
              state_d = HOLD;
            end
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = COLLECT_A;
        end
      end
      default: state_d = COLLECT_A;
    endcase

    // Early tlast discards the partial step and resynchronises to A-word 0 of k=0.
    if (accept && s_axis_tlast && !final_of_packet) begin
      err_d   = 1'b1;
      load    = 1'b0;
      k_d     = '0;
      widx_d  = '0;
      state_d = COLLECT_A;
    end

    if (load) begin
      out_a_d     = a_stage_d;
      out_b_d     = b_stage_d;
      out_valid_d = 1'b1;
      out_first_d = (k_q == '0);
      out_last_d  = (k_q == KW'(K_DEPTH - 1));
      k_d         = (k_q == KW'(K_DEPTH - 1)) ? '0 : k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT_A;
      widx_q      <= '0;
      k_q         <= '0;
      a_stage_q   <= '0;
      b_stage_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      k_q         <= k_d;
      a_stage_q   <= a_stage_d;
      b_stage_q   <= b_stage_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign err_len   = err_q;
endmodule
